// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared constants and write-FSM state encoding for the RS(16,8) message framer
package rs_pkg;

  localparam int SYM_BW = 8;
  localparam int N_NUM  = 16;
  localparam int K_NUM  = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rs_cmt_fifo.sv
// rtl/rs_cmt_fifo.sv - FIFO with speculative write pointer, commit pointer and rewind
module rs_cmt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rewind,
  input  logic                     commit,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     rd_avail,
  output logic [$clog2(DEPTH):0]   free,
  output logic [$clog2(DEPTH):0]   free_cmt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  cmt_ptr_q, cmt_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  wr_base;
  logic [W-1:0] mem_q [DEPTH];

  // A rewind and a fresh write in the same cycle land at the old commit point.
  always_comb begin
    wr_base   = rewind ? cmt_ptr_q : wr_ptr_q;
    wr_ptr_d  = wr_base + {{AW{1'b0}}, wr_en};
    cmt_ptr_d = commit ? wr_ptr_d : cmt_ptr_q;
    rd_avail  = (cmt_ptr_q != rd_ptr_q);
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_en & rd_avail};
    rd_data   = mem_q[rd_ptr_q[AW-1:0]];
    free      = DEPTH_L - (wr_ptr_q - rd_ptr_q);
    free_cmt  = DEPTH_L - (cmt_ptr_q - rd_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_base[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/rs_dec_msg_framer_16_8.sv
// rtl/rs_dec_msg_framer_16_8.sv - strips RS parity and emits atomic message frames with sop/eop
module rs_dec_msg_framer_16_8 #(
  parameter int SYM_BW = rs_pkg::SYM_BW,
  parameter int N_NUM  = rs_pkg::N_NUM,
  parameter int K_NUM  = rs_pkg::K_NUM,
  parameter int DEPTH  = rs_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_in_val,
  input  logic [7:0]        sym_in_cnt,
  input  logic [SYM_BW-1:0] sym_in,
  input  logic              dout_rdy,
  output logic              dout_val,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [SYM_BW-1:0] dout,
  output logic              ovf_err,
  output logic              proto_err,
  output logic [15:0]       frm_cnt
);

  import rs_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int EW = SYM_BW + 2;
  localparam logic [7:0]  K_LAST = 8'(K_NUM - 1);
  localparam logic [7:0]  N_LIM  = 8'(N_NUM);
  localparam logic [AW:0] K_FREE = (AW+1)'(K_NUM);

  wr_state_e   state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic        ovf_q, ovf_d;
  logic        proto_q, proto_d;
  logic        out_val_q, out_val_d;
  logic [EW-1:0] out_q, out_d;
  logic [15:0] frm_cnt_q, frm_cnt_d;

  logic          sym_ok, start;
  logic          wr_en, wr_sop, wr_eop, rewind, commit, rd_en;
  logic [AW:0]   free, free_cmt, free_sel;
  logic [EW-1:0] rd_data;
  logic          rd_avail;

  rs_cmt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  ({wr_sop, wr_eop, sym_in}),
    .rewind   (rewind),
    .commit   (commit),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_avail (rd_avail),
    .free     (free),
    .free_cmt (free_cmt)
  );

  // Out-of-range indices are not legal codeword positions and are treated as no symbol.
  assign sym_ok = sym_in_val & (sym_in_cnt < N_LIM);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    ovf_d    = ovf_q;
    proto_d  = proto_q;
    wr_en    = 1'b0;
    wr_sop   = 1'b0;
    wr_eop   = 1'b0;
    rewind   = 1'b0;
    commit   = 1'b0;
    start    = 1'b0;
    free_sel = free;
    if (sym_ok) begin
      case (state_q)
        ST_IDLE, ST_DROP: start = (sym_in_cnt == 8'd0);
        ST_PASS: begin
          if (sym_in_cnt == exp_q) begin
            wr_en = 1'b1;
            if (exp_q == K_LAST) begin
              wr_eop  = 1'b1;
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              exp_d = exp_q + 8'd1;
            end
          end else begin
            // Abandon the partial frame; a new sop may restart in this very cycle.
            rewind   = 1'b1;
            proto_d  = 1'b1;
            state_d  = ST_IDLE;
            start    = (sym_in_cnt == 8'd0);
            free_sel = free_cmt;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (start) begin
        if (free_sel >= K_FREE) begin
          wr_en   = 1'b1;
          wr_sop  = 1'b1;
          exp_d   = 8'd1;
          state_d = ST_PASS;
        end else begin
          ovf_d   = 1'b1;
          state_d = ST_DROP;
        end
      end
    end
  end

  // Output register: refills whenever empty or being consumed this cycle.
  always_comb begin
    rd_en     = rd_avail & (~out_val_q | dout_rdy);
    out_val_d = rd_en | (out_val_q & ~dout_rdy);
    out_d     = rd_en ? rd_data : out_q;
    frm_cnt_d = frm_cnt_q + {15'd0, out_val_q & dout_rdy & out_q[EW-2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
      out_val_q <= 1'b0;
      out_q     <= '0;
      frm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      ovf_q     <= ovf_d;
      proto_q   <= proto_d;
      out_val_q <= out_val_d;
      out_q     <= out_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign dout_val  = out_val_q;
  assign dout_sop  = out_q[EW-1];
  assign dout_eop  = out_q[EW-2];
  assign dout      = out_q[SYM_BW-1:0];
  assign ovf_err   = ovf_q;
  assign proto_err = proto_q;
  assign frm_cnt   = frm_cnt_q;

endmodule
